fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of instr_mem.
- Owns the program counter and drives the memory address a_instr.
- Captures the returned rd_instr into the IF/ID pipeline register, together with its PC and PC+4.
- Handles decode-stage stall, decode flush and execute-stage redirect (branch/jump target).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on reset/flush.
- TRAP_VEC, 32'h0000_0100, redirect address for a misaligned target (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_f  in  1  hold PC and IF/ID register this cycle.
- flush_d  in  1  replace IF/ID contents with a bubble.
- pc_src_e  in  1  redirect request from execute.
- pc_target_e  in  32  redirect target address.
- a_instr  out  32  instruction memory address (combinational copy of PC).
- rd_instr  in  32  instruction word returned by instr_mem, same cycle (combinational read).
- instr_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC of instr_d.
- pc_plus4_d  out  32  IF/ID pc_d+4.
- valid_d  out  1  IF/ID holds a real instruction.
- misalign_trap  out  1  pulse on misaligned redirect (optional feature only).

Behaviour:
- Reset is asynchronous and active-high; it is applied immediately, independent of clk.
  - PC = RESET_PC, so a_instr = RESET_PC.
  - instr_d = NOP_INSTR, pc_d = 0, pc_plus4_d = 0, valid_d = 0, misalign_trap = 0.
- a_instr = PC combinationally; no extra register. Fetch latency: the word for PC appears on instr_d one clock edge later.
- Each rising edge resolves in this priority order:
  1. rst: reset values as above.
  2. pc_src_e=1:
     - PC <= aligned target.
     - IF/ID <= bubble (instr_d=NOP_INSTR, valid_d=0, pc_d/pc_plus4_d hold).
     - Overrides stall_f and flush_d in the same cycle.
  3. stall_f=1: PC and all IF/ID outputs hold.
     - If flush_d=1 in the same cycle, the flush wins for IF/ID (bubble) while PC still holds.
  4. flush_d=1:
     - PC <= PC+4.
     - IF/ID <= bubble.
  5. Otherwise:
     - PC <= PC+4.
     - instr_d <= rd_instr, pc_d <= PC, pc_plus4_d <= PC+4, valid_d <= 1.
- Arithmetic: PC+4 is a 32-bit modulo add; 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- Alignment (feature disabled): the aligned target is {pc_target_e[31:2],2'b00}, i.e. bits [1:0] are silently cleared.
- No internal state beyond the PC, the IF/ID fields and misalign_trap. Deasserting reset mid-program restarts fetch at RESET_PC on the first edge after release.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with pc_target_e[1:0] != 0 loads PC <= TRAP_VEC instead of the target.
  - IF/ID gets a bubble.
  - misalign_trap is high for exactly one cycle after that edge.
  - An aligned redirect behaves normally with misalign_trap=0.
- Not defined:
  - The misalign_trap port is absent.
  - Low target bits are cleared as in Behaviour.

Test Plan:
- Reset then run 4 cycles, rd_instr modelled as memory word[addr>>2] -> a_instr steps 0,4,8,12; instr_d/pc_d follow one cycle later; valid_d goes 0 then 1.
- Assert stall_f for 2 cycles at PC=8 -> a_instr stays 8, instr_d/pc_d unchanged; fetch resumes at 12 afterwards with no instruction lost or duplicated.
- pc_src_e=1, pc_target_e=32'h40 while stall_f=1 -> next a_instr=0x40, instr_d=0x00000013, valid_d=0; word at 0x40 reaches instr_d one cycle later.
- flush_d=1 alone at PC=0x10 -> a_instr=0x14, instr_d=NOP, valid_d=0.
- Redirect to 32'hFFFF_FFFC, then free-run -> a_instr wraps to 0x0; pc_plus4_d for pc_d=0xFFFF_FFFC equals 0.
- Redirect to 0x42 -> without macro, a_instr=0x40; with FETCH_MISALIGN_TRAP_EN, a_instr=0x100 and misalign_trap high for exactly one cycle. Assert rst asynchronously mid-stream (between edges) -> a_instr=0 and valid_d=0 immediately.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instr_mem address, fills the IF/ID register.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirects go to TRAP_VEC and pulse misalign_trap.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic [31:0] a_instr,
  input  logic [31:0] rd_instr,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign_trap
`endif
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;
  logic [31:0] redirect_pc;
  logic        target_misaligned;

  assign a_instr           = pc;
  assign pc_plus4          = pc + 32'd4;
  assign target_aligned    = {pc_target_e[31:2], 2'b00};
  assign target_misaligned = |pc_target_e[1:0];

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_pc = target_misaligned ? TRAP_VEC : target_aligned;
`else
  // Low target bits are silently dropped; the trap vector has no use here.
  logic unused_misalign;
  assign unused_misalign = ^{target_misaligned, TRAP_VEC};
  assign redirect_pc     = target_aligned;
`endif

  // Priority: redirect > stall (flush still bubbles IF/ID) > flush > sequential fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      instr_d    <= NOP_INSTR;
      pc_d       <= 32'd0;
      pc_plus4_d <= 32'd0;
      valid_d    <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_trap <= 1'b0;
`endif
    end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_trap <= pc_src_e & target_misaligned;
`endif
      if (pc_src_e) begin
        pc      <= redirect_pc;
        instr_d <= NOP_INSTR;
        valid_d <= 1'b0;
      end else if (stall_f) begin
        if (flush_d) begin
          instr_d <= NOP_INSTR;
          valid_d <= 1'b0;
        end
      end else if (flush_d) begin
        pc      <= pc_plus4;
        instr_d <= NOP_INSTR;
        valid_d <= 1'b0;
      end else begin
        pc         <= pc_plus4;
        instr_d    <= rd_instr;
        pc_d       <= pc;
        pc_plus4_d <= pc_plus4;
        valid_d    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random control against a reference model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_f = 1'b0, flush_d = 1'b0, pc_src_e = 1'b0;
  logic [31:0] pc_target_e = 32'd0;
  logic [31:0] a_instr, rd_instr, instr_d, pc_d, pc_plus4_d;
  logic        valid_d;
  logic        misalign_trap;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4;
  logic        m_valid, m_trap;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return ((addr >> 2) * 32'h0101_0107) ^ 32'h1357_9BDF;
  endfunction

  assign rd_instr = mem_word(a_instr);

`ifndef FETCH_MISALIGN_TRAP_EN
  assign misalign_trap = 1'b0;
`endif

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst(rst), .stall_f(stall_f), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .a_instr(a_instr),
    .rd_instr(rd_instr), .instr_d(instr_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .misalign_trap(misalign_trap)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = NOP_INSTR; m_pcd = 32'd0; m_pc4 = 32'd0;
    m_valid = 1'b0; m_trap = 1'b0;
  endtask

  task automatic model_edge(input bit s, input bit f, input bit r, input logic [31:0] t);
    logic [31:0] seq_pc;
    seq_pc = m_pc + 32'd4;
    m_trap = 1'b0;
    if (r) begin
      if (TRAP_EN && t[1:0] != 2'b00) begin
        m_pc = TRAP_VEC; m_trap = 1'b1;
      end else begin
        m_pc = t & 32'hFFFF_FFFC;
      end
      m_instr = NOP_INSTR; m_valid = 1'b0;
    end else if (s) begin
      if (f) begin m_instr = NOP_INSTR; m_valid = 1'b0; end
    end else if (f) begin
      m_pc = seq_pc; m_instr = NOP_INSTR; m_valid = 1'b0;
    end else begin
      m_instr = mem_word(m_pc); m_pcd = m_pc; m_pc4 = seq_pc; m_valid = 1'b1;
      m_pc = seq_pc;
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".a_instr"}, a_instr, m_pc);
    check_eq({tag, ".instr_d"}, instr_d, m_instr);
    check_eq({tag, ".pc_d"}, pc_d, m_pcd);
    check_eq({tag, ".pc_plus4_d"}, pc_plus4_d, m_pc4);
    check_eq({tag, ".valid_d"}, {31'd0, valid_d}, {31'd0, m_valid});
    if (TRAP_EN) check_eq({tag, ".trap"}, {31'd0, misalign_trap}, {31'd0, m_trap});
  endtask

  // Drive controls at the falling edge, take one rising edge, check at the next falling edge.
  task automatic step(input string tag, input bit s, input bit f, input bit r, input logic [31:0] t);
    stall_f = s; flush_d = f; pc_src_e = r; pc_target_e = t;
    @(posedge clk);
    model_edge(s, f, r, t);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    check_eq("reset.a_instr_const", a_instr, 32'h0);
    rst = 1'b0;

    step("run0", 0, 0, 0, 0);
    check_eq("run0.a4", a_instr, 32'h4);
    check_eq("run0.valid", {31'd0, valid_d}, 32'd1);
    step("run1", 0, 0, 0, 0);
    check_eq("run1.a8", a_instr, 32'h8);
    check_eq("run1.instr", instr_d, mem_word(32'h4));

    step("stall0", 1, 0, 0, 0);
    step("stall1", 1, 0, 0, 0);
    check_eq("stall.a_hold", a_instr, 32'h8);
    check_eq("stall.pcd_hold", pc_d, 32'h4);
    step("resume", 0, 0, 0, 0);
    check_eq("resume.a12", a_instr, 32'hC);
    check_eq("resume.pcd", pc_d, 32'h8);
    check_eq("resume.instr", instr_d, mem_word(32'h8));
    step("to10", 0, 0, 0, 0);

    step("flush", 0, 1, 0, 0);
    check_eq("flush.a14", a_instr, 32'h14);
    check_eq("flush.nop", instr_d, NOP_INSTR);

    step("redir_stall", 1, 1, 1, 32'h40);
    check_eq("redir.a40", a_instr, 32'h40);
    check_eq("redir.valid", {31'd0, valid_d}, 32'd0);
    step("after_redir", 0, 0, 0, 0);
    check_eq("after_redir.instr", instr_d, mem_word(32'h40));
    check_eq("after_redir.pcd", pc_d, 32'h40);

    step("wrap_redir", 0, 0, 1, 32'hFFFF_FFFC);
    step("wrap_run", 0, 0, 0, 0);
    check_eq("wrap.a0", a_instr, 32'h0);
    check_eq("wrap.pcd", pc_d, 32'hFFFF_FFFC);
    check_eq("wrap.pc4", pc_plus4_d, 32'h0);

    step("mis_redir", 0, 0, 1, 32'h42);
    check_eq("mis.a", a_instr, TRAP_EN ? TRAP_VEC : 32'h40);
    step("mis_after", 0, 0, 0, 0);
    if (TRAP_EN) check_eq("mis.trap_drop", {31'd0, misalign_trap}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
      step("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
           $urandom_range(0, 9) == 0, t);
    end

    // asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_eq("async.a0", a_instr, 32'h0);
    check_eq("async.valid", {31'd0, valid_d}, 32'd0);
    check_eq("async.nop", instr_d, NOP_INSTR);
    @(negedge clk);
    check_all("async_hold");
    rst = 1'b0;
    step("restart", 0, 0, 0, 0);
    check_eq("restart.pcd", pc_d, RESET_PC);
    check_eq("restart.a", a_instr, RESET_PC + 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
